// File: rtl/cr_su_stats_regfile.sv
// Statistics register-file slave: history-buffer snapshot capture, event counters
// with saturation / clear-on-read, and a high-word latch for coherent 64-bit reads.
module cr_su_stats_regfile #(
    parameter int N_CH      = 8,
    parameter int HB_WIDTH  = 108,
    parameter int N_CNT     = 4,
    parameter int CNT_BITS  = 48,
    parameter int BY_BITS   = 2,
    parameter int ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_BITS-1:0]      locl_addr,
    input  logic                      locl_wr_strb,
    input  logic [31:0]               locl_wr_data,
    input  logic                      locl_rd_strb,
    output logic [31:0]               locl_rd_data,
    output logic                      locl_ack,
    output logic                      locl_err_ack,
    input  logic [N_CH*HB_WIDTH-1:0]  hb_i,
    input  logic [N_CNT-1:0]          count_stb,
    input  logic [N_CNT*BY_BITS-1:0]  count_by,
    output logic [15:0]               ctrl_o
);
    localparam int HB_WORDS   = (HB_WIDTH + 31) / 32;
    localparam int SNAP_WORDS = N_CH * HB_WORDS;
    localparam int CNT_IW     = (N_CNT > 1) ? $clog2(N_CNT) : 1;
    localparam int SNAP_IW    = (SNAP_WORDS > 1) ? $clog2(SNAP_WORDS) : 1;

    localparam logic [31:0] ADDR_CTRL   = 32'h000;
    localparam logic [31:0] ADDR_STATUS = 32'h001;
    localparam logic [31:0] ADDR_CNT_HI = 32'h002;
    localparam logic [31:0] ADDR_CNT_LO = 32'h010;
    localparam logic [31:0] ADDR_SNAP   = 32'h100;
    localparam logic [15:0] CTRL_WMASK  = 16'hFF06;

    logic [15:0]         ctrl_reg;
    logic                capture_reg;
    logic                snap_valid_reg;
    logic [7:0]          snap_seq_reg;
    logic [31:0]         cnt_hi_reg;
    logic                ack_reg;
    logic                err_reg;
    logic [31:0]         rd_data_reg;
    logic [31:0]         snap_reg  [SNAP_WORDS];
    logic [31:0]         snap_load [SNAP_WORDS];
    logic [CNT_BITS-1:0] cnt_val   [N_CNT];

    logic [31:0]         addr32;
    logic [31:0]         cnt_off;
    logic [31:0]         snap_off;
    logic [CNT_IW-1:0]   cnt_idx;
    logic [SNAP_IW-1:0]  snap_idx;
    logic                is_ctrl, is_status, is_cnt_hi, is_cnt_lo, is_snap, mapped;
    logic                rd_ok, wr_ok, req_err, cnt_rd_ok;
    logic [63:0]         cnt_sel_ext;
    logic [31:0]         rd_word;
    logic                unused_bits;

    assign addr32    = 32'(locl_addr);
    assign cnt_off   = addr32 - ADDR_CNT_LO;
    assign snap_off  = addr32 - ADDR_SNAP;
    assign cnt_idx   = cnt_off[CNT_IW-1:0];
    assign snap_idx  = snap_off[SNAP_IW-1:0];

    assign is_ctrl   = (addr32 == ADDR_CTRL);
    assign is_status = (addr32 == ADDR_STATUS);
    assign is_cnt_hi = (addr32 == ADDR_CNT_HI);
    assign is_cnt_lo = (addr32 >= ADDR_CNT_LO) && (addr32 < ADDR_CNT_LO + 32'(N_CNT));
    assign is_snap   = (addr32 >= ADDR_SNAP) && (addr32 < ADDR_SNAP + 32'(SNAP_WORDS));
    assign mapped    = is_ctrl | is_status | is_cnt_hi | is_cnt_lo | is_snap;

    // Only CTRL is writable; a simultaneous read+write is rejected outright.
    assign rd_ok     = locl_rd_strb & ~locl_wr_strb & mapped;
    assign wr_ok     = locl_wr_strb & ~locl_rd_strb & is_ctrl;
    assign req_err   = (locl_rd_strb | locl_wr_strb) & ~(rd_ok | wr_ok);
    assign cnt_rd_ok = rd_ok & is_cnt_lo;

    assign cnt_sel_ext = 64'(cnt_val[cnt_idx]);
    assign unused_bits = ^{locl_wr_data[31:16], cnt_off[31:CNT_IW], snap_off[31:SNAP_IW]};

    always_comb begin
        rd_word = '0;
        if (is_ctrl)        rd_word = {16'h0, ctrl_reg};
        else if (is_status) rd_word = {16'h0, snap_seq_reg, 7'h0, snap_valid_reg};
        else if (is_cnt_hi) rd_word = cnt_hi_reg;
        else if (is_cnt_lo) rd_word = cnt_sel_ext[31:0];
        else if (is_snap)   rd_word = snap_reg[snap_idx];
    end

    // Each channel is zero-extended to a whole number of words before slicing.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : gen_ch
            logic [HB_WORDS*32-1:0] hb_pad;
            assign hb_pad = (HB_WORDS*32)'(hb_i[gi*HB_WIDTH +: HB_WIDTH]);
            for (gj = 0; gj < HB_WORDS; gj++) begin : gen_word
                assign snap_load[gi*HB_WORDS+gj] = hb_pad[gj*32 +: 32];
            end
        end

        for (gi = 0; gi < N_CNT; gi++) begin : gen_cnt
            logic [CNT_BITS-1:0] cnt_q;
            logic [CNT_BITS-1:0] inc;
            logic [CNT_BITS:0]   sum;
            logic                clr;
            assign inc = count_stb[gi] ? CNT_BITS'(count_by[gi*BY_BITS +: BY_BITS]) : '0;
            assign sum = {1'b0, cnt_q} + {1'b0, inc};
            assign clr = cnt_rd_ok & ctrl_reg[1] & (cnt_idx == CNT_IW'(gi));
            // Clear-on-read keeps this cycle's increment so no event is lost.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                            cnt_q <= '0;
                else if (clr)                       cnt_q <= inc;
                else if (sum[CNT_BITS] && ctrl_reg[2]) cnt_q <= '1;
                else                                cnt_q <= sum[CNT_BITS-1:0];
            end
            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg       <= '0;
            capture_reg    <= 1'b0;
            snap_valid_reg <= 1'b0;
            snap_seq_reg   <= '0;
            cnt_hi_reg     <= '0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            ack_reg     <= rd_ok | wr_ok;
            err_reg     <= req_err;
            rd_data_reg <= rd_ok ? rd_word : 32'h0;
            capture_reg <= wr_ok & locl_wr_data[0];
            if (wr_ok)
                ctrl_reg <= locl_wr_data[15:0] & CTRL_WMASK;
            if (capture_reg) begin
                snap_valid_reg <= 1'b1;
                snap_seq_reg   <= snap_seq_reg + 8'd1;
            end
            if (cnt_rd_ok)
                cnt_hi_reg <= cnt_sel_ext[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SNAP_WORDS; i++) snap_reg[i] <= '0;
        end else if (capture_reg) begin
            for (int i = 0; i < SNAP_WORDS; i++) snap_reg[i] <= snap_load[i];
        end
    end

    assign locl_rd_data = rd_data_reg;
    assign locl_ack     = ack_reg;
    assign locl_err_ack = err_reg;
    assign ctrl_o       = ctrl_reg;
endmodule

// File: tb/tb_cr_su_stats_regfile.sv
// Directed self-checking bench for cr_su_stats_regfile with default parameters.
module tb_cr_su_stats_regfile;
    localparam int N_CH = 8, HB_WIDTH = 108, N_CNT = 4, CNT_BITS = 48, BY_BITS = 2, ADDR_BITS = 12;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [ADDR_BITS-1:0]     locl_addr = '0;
    logic                     locl_wr_strb = 1'b0;
    logic [31:0]              locl_wr_data = '0;
    logic                     locl_rd_strb = 1'b0;
    logic [31:0]              locl_rd_data;
    logic                     locl_ack;
    logic                     locl_err_ack;
    logic [N_CH*HB_WIDTH-1:0] hb_i = '0;
    logic [N_CNT-1:0]         count_stb = '0;
    logic [N_CNT*BY_BITS-1:0] count_by = '0;
    logic [15:0]              ctrl_o;

    int errors = 0;
    int checks = 0;
    logic        r_ack, r_err;
    logic [31:0] r_data;

    cr_su_stats_regfile #(
        .N_CH(N_CH), .HB_WIDTH(HB_WIDTH), .N_CNT(N_CNT),
        .CNT_BITS(CNT_BITS), .BY_BITS(BY_BITS), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .locl_addr(locl_addr), .locl_wr_strb(locl_wr_strb), .locl_wr_data(locl_wr_data),
        .locl_rd_strb(locl_rd_strb), .locl_rd_data(locl_rd_data),
        .locl_ack(locl_ack), .locl_err_ack(locl_err_ack),
        .hb_i(hb_i), .count_stb(count_stb), .count_by(count_by), .ctrl_o(ctrl_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: strobe for exactly one clock edge, then sample the response.
    task automatic req(input logic wr, input logic rd, input logic [11:0] addr,
                       input logic [31:0] wdata);
        @(negedge clk);
        locl_wr_strb = wr; locl_rd_strb = rd; locl_addr = addr; locl_wr_data = wdata;
        @(negedge clk);
        locl_wr_strb = 1'b0; locl_rd_strb = 1'b0;
        r_ack = locl_ack; r_err = locl_err_ack; r_data = locl_rd_data;
        $display("req wr=%0b rd=%0b addr=%h wdata=%h -> ack=%0b err=%0b data=%h",
                 wr, rd, addr, wdata, r_ack, r_err, r_data);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        req(1'b0, 1'b1, addr, 32'h0);
        check({tag, "_ack"}, 64'(r_ack), 64'd1);
        check({tag, "_err"}, 64'(r_err), 64'd0);
        check(tag, 64'(r_data), 64'(exp));
    endtask

    task automatic wr_ctrl(input logic [31:0] val);
        req(1'b1, 1'b0, 12'h000, val);
        check("wr_ctrl_ack", 64'({r_ack, r_err, r_data}), {31'h0, 1'b1, 1'b0, 32'h0});
    endtask

    task automatic pulse_cnt(input int k, input logic [1:0] by);
        @(negedge clk);
        count_stb[k] = 1'b1; count_by[k*BY_BITS +: BY_BITS] = by;
        @(negedge clk);
        count_stb = '0; count_by = '0;
    endtask

    logic [HB_WIDTH-1:0] hb3;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(locl_ack), 64'd0);
        check("rst_data", 64'(locl_rd_data), 64'd0);
        rst = 1'b0;
        check("rst_ctrl_o", 64'(ctrl_o), 64'd0);

        rd_chk("status_reset", 12'h001, 32'h0);
        req(1'b0, 1'b1, 12'h003, 32'h0);
        check("unmapped_err", 64'({r_ack, r_err}), 64'b01);
        check("unmapped_data", 64'(r_data), 64'd0);
        req(1'b1, 1'b0, 12'h001, 32'h5);
        check("wr_ro_err", 64'({r_ack, r_err}), 64'b01);

        // CTRL masking: only bits 15:8, 2, 1 stick; bit0 is a pulse
        wr_ctrl(32'h0000_FFFE);
        check("ctrl_o_mask", 64'(ctrl_o), 64'hFF06);
        rd_chk("ctrl_rd", 12'h000, 32'h0000_FF06);
        wr_ctrl(32'h0);

        // Snapshot of channel 3 plus an all-ones channel 0
        hb3 = 108'hABC_0123_4567_89AB_CDEF_0123_4567;
        hb_i[3*HB_WIDTH +: HB_WIDTH] = hb3;
        hb_i[0 +: HB_WIDTH] = '1;
        wr_ctrl(32'h1);
        @(posedge clk); #1;
        hb_i = '0;
        check("ctrl_o_bit0", 64'(ctrl_o), 64'h0);
        rd_chk("snap3_w0", 12'h10C, 32'h0123_4567);
        rd_chk("snap3_w1", 12'h10D, 32'h89AB_CDEF);
        rd_chk("snap3_w2", 12'h10E, 32'h0123_4567);
        rd_chk("snap3_w3", 12'h10F, 32'h0000_0ABC);
        rd_chk("snap0_w3", 12'h103, 32'h0000_0FFF);
        rd_chk("status_1", 12'h001, 32'h0000_0101);
        req(1'b0, 1'b1, 12'h120, 32'h0);
        check("snap_oob_err", 64'({r_ack, r_err}), 64'b01);

        // Second freeze picks up new live value and bumps sequence
        hb_i[3*HB_WIDTH +: HB_WIDTH] = 108'h5A;
        wr_ctrl(32'h1);
        @(posedge clk); #1;
        rd_chk("snap3_w0_2", 12'h10C, 32'h0000_005A);
        rd_chk("status_2", 12'h001, 32'h0000_0201);

        // Counter 3 plain increments: 1 + 3 + 0 = 4
        pulse_cnt(3, 2'd1);
        pulse_cnt(3, 2'd3);
        pulse_cnt(3, 2'd0);
        rd_chk("cnt3_sum", 12'h013, 32'd4);

        // 48-bit coherent read via CNT_HI latch
        @(negedge clk);
        force dut.gen_cnt[1].cnt_q = 48'h0001_0000_0005;
        @(negedge clk);
        release dut.gen_cnt[1].cnt_q;
        rd_chk("cnt1_lo", 12'h011, 32'h0000_0005);
        rd_chk("cnt1_hi", 12'h002, 32'h0000_0001);
        rd_chk("cnt1_hi_again", 12'h002, 32'h0000_0001);
        rd_chk("cnt1_no_clr", 12'h011, 32'h0000_0005);

        // Saturation on, then modulo wrap
        wr_ctrl(32'h4);
        @(negedge clk);
        force dut.gen_cnt[2].cnt_q = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.gen_cnt[2].cnt_q;
        pulse_cnt(2, 2'd3);
        rd_chk("cnt2_sat_lo", 12'h012, 32'hFFFF_FFFF);
        rd_chk("cnt2_sat_hi", 12'h002, 32'h0000_FFFF);
        wr_ctrl(32'h0);
        @(negedge clk);
        force dut.gen_cnt[2].cnt_q = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.gen_cnt[2].cnt_q;
        pulse_cnt(2, 2'd3);
        rd_chk("cnt2_wrap_lo", 12'h012, 32'h0000_0002);
        rd_chk("cnt2_wrap_hi", 12'h002, 32'h0000_0000);

        // Clear-on-read with a coincident strobe
        wr_ctrl(32'h2);
        @(negedge clk);
        force dut.gen_cnt[0].cnt_q = 48'd7;
        @(negedge clk);
        release dut.gen_cnt[0].cnt_q;
        @(negedge clk);
        locl_rd_strb = 1'b1; locl_addr = 12'h010; count_stb[0] = 1'b1; count_by[1:0] = 2'd2;
        @(negedge clk);
        locl_rd_strb = 1'b0; count_stb = '0; count_by = '0;
        $display("cor read with strobe -> ack=%0b data=%h", locl_ack, locl_rd_data);
        check("cor_first", 64'({locl_ack, locl_rd_data}), {31'h0, 1'b1, 32'd7});
        rd_chk("cor_second", 12'h010, 32'd2);
        rd_chk("cor_third", 12'h010, 32'd0);

        // Simultaneous write and read strobe: error only, CTRL untouched
        req(1'b1, 1'b1, 12'h000, 32'h0000_FF04);
        check("both_strb", 64'({r_ack, r_err, r_data}), {31'h0, 1'b0, 1'b1, 32'h0});
        check("both_ctrl_kept", 64'(ctrl_o), 64'h0002);

        // Reset in the cycle after a read strobe drops the pending ack
        @(negedge clk);
        locl_rd_strb = 1'b1; locl_addr = 12'h001;
        @(posedge clk); #1;
        locl_rd_strb = 1'b0; rst = 1'b1;
        #1;
        $display("rst mid-transaction -> ack=%0b err=%0b data=%h ctrl=%h",
                 locl_ack, locl_err_ack, locl_rd_data, ctrl_o);
        check("midrst_outs", 64'({locl_ack, locl_err_ack, locl_rd_data, ctrl_o}), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", 64'({locl_ack, locl_err_ack}), 64'h0);
        rd_chk("status_after_rst", 12'h001, 32'h0);
        rd_chk("snap_after_rst", 12'h10C, 32'h0);
        rd_chk("cnt3_after_rst", 12'h013, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
